// File: rtl/carwash_pkg.sv
// Shared types and default constants for the car wash timer responder.
package carwash_pkg;

   // One-hot, matching the encoding used by the wash controller.
   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      LOAD = 4'b0010,
      RUN  = 4'b0100,
      DONE = 4'b1000
   } timer_state_t;

   localparam int CW_PRESCALE = 100;
   localparam int CW_T1_LEN   = 5;
   localparam int CW_T2_LEN   = 8;
   localparam int CW_CNT_W    = 8;

endpackage

// File: rtl/wash_timer.sv
// One timer channel: prescaled down-counter with IDLE/LOAD/RUN/DONE control.
// Optional remaining-tick output under CARWASH_TIMER_REM_EN.
module wash_timer
   import carwash_pkg::*;
#(
   parameter int PRESCALE = CW_PRESCALE,
   parameter int LEN      = CW_T1_LEN,
   parameter int CNT_W    = CW_CNT_W
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             clr_in,
`ifdef CARWASH_TIMER_REM_EN
   output logic [CNT_W-1:0] rem,
`endif
   output logic             done
);

   localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);

   if (PRESCALE < 1 || LEN < 1 || CNT_W < 1 || LEN > (2**CNT_W - 1)) begin : g_param_err
      $error("wash_timer: parameter out of range");
   end

   timer_state_t     r_state;
   timer_state_t     w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [PS_W-1:0]  r_ps;
   logic [PS_W-1:0]  w_ps_nxt;
   logic             r_done;

   // State, counter, prescaler and done flag registers.
   always_ff @(posedge clk) begin
      if (CLR) begin
         r_state <= IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_ps    <= {PS_W{1'b0}};
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ps    <= w_ps_nxt;
         r_done  <= (w_state_nxt == DONE);
      end
   end

   // Next-state logic; a clear from any non-idle-hold state reloads the count.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ps_nxt    = r_ps;
      case (r_state)
         IDLE, DONE: begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_ps_nxt  = {PS_W{1'b0}};
            if (clr_in) begin
               w_state_nxt = LOAD;
               w_cnt_nxt   = LEN_C;
            end else begin
               w_state_nxt = r_state;
            end
         end
         LOAD: begin
            w_cnt_nxt = LEN_C;
            w_ps_nxt  = {PS_W{1'b0}};
            if (clr_in) begin
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (clr_in) begin
               w_state_nxt = LOAD;
               w_cnt_nxt   = LEN_C;
               w_ps_nxt    = {PS_W{1'b0}};
            end else if (r_ps == PS_LAST) begin
               w_ps_nxt  = {PS_W{1'b0}};
               w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = RUN;
               end
            end else begin
               w_ps_nxt = r_ps + PS_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_ps_nxt    = {PS_W{1'b0}};
         end
      endcase
   end

   assign done = r_done;
`ifdef CARWASH_TIMER_REM_EN
   // The count register is already LEN in LOAD and 0 in IDLE/DONE.
   assign rem = r_cnt;
`endif

endmodule

// File: rtl/carwash_timer.sv
// Spray (T1) and rinse (T2) timer responder for the car wash controller.
// Define CARWASH_TIMER_REM_EN to expose remaining-tick outputs T1REM/T2REM.
module carwash_timer
   import carwash_pkg::*;
#(
   parameter int PRESCALE = CW_PRESCALE,
   parameter int T1_LEN   = CW_T1_LEN,
   parameter int T2_LEN   = CW_T2_LEN,
   parameter int CNT_W    = CW_CNT_W
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             CLRT1,
   input  logic             CLRT2,
`ifdef CARWASH_TIMER_REM_EN
   output logic [CNT_W-1:0] T1REM,
   output logic [CNT_W-1:0] T2REM,
`endif
   output logic             T1DONE,
   output logic             T2DONE
);

   if (PRESCALE < 1 || T1_LEN < 1 || T2_LEN < 1 || CNT_W < 1 ||
       T1_LEN > (2**CNT_W - 1) || T2_LEN > (2**CNT_W - 1)) begin : g_param_err
      $error("carwash_timer: parameter out of range");
   end

   wash_timer #(.PRESCALE(PRESCALE), .LEN(T1_LEN), .CNT_W(CNT_W)) u_spray (
      .clk    (clk),
      .CLR    (CLR),
      .clr_in (CLRT1),
`ifdef CARWASH_TIMER_REM_EN
      .rem    (T1REM),
`endif
      .done   (T1DONE)
   );

   wash_timer #(.PRESCALE(PRESCALE), .LEN(T2_LEN), .CNT_W(CNT_W)) u_rinse (
      .clk    (clk),
      .CLR    (CLR),
      .clr_in (CLRT2),
`ifdef CARWASH_TIMER_REM_EN
      .rem    (T2REM),
`endif
      .done   (T2DONE)
   );

endmodule

// File: tb/tb_carwash_timer.sv
// Self-checking bench: DUT A (PRESCALE=4, T1_LEN=3, T2_LEN=2) and DUT B
// (PRESCALE=1, T1_LEN=T2_LEN=1) share stimulus; an elapsed-edge model checks both.
module tb_carwash_timer;

   localparam int CW = 8;

   logic clk;
   logic CLR, CLRT1, CLRT2;
   logic a_t1, a_t2, b_t1, b_t2;
`ifdef CARWASH_TIMER_REM_EN
   logic [CW-1:0] a_r1, a_r2, b_r1, b_r2;
`endif

   int n_checks = 0;
   int n_errors = 0;

   carwash_timer #(.PRESCALE(4), .T1_LEN(3), .T2_LEN(2), .CNT_W(CW)) dut_a (
      .clk(clk), .CLR(CLR), .CLRT1(CLRT1), .CLRT2(CLRT2),
`ifdef CARWASH_TIMER_REM_EN
      .T1REM(a_r1), .T2REM(a_r2),
`endif
      .T1DONE(a_t1), .T2DONE(a_t2)
   );

   carwash_timer #(.PRESCALE(1), .T1_LEN(1), .T2_LEN(1), .CNT_W(CW)) dut_b (
      .clk(clk), .CLR(CLR), .CLRT1(CLRT1), .CLRT2(CLRT2),
`ifdef CARWASH_TIMER_REM_EN
      .T1REM(b_r1), .T2REM(b_r2),
`endif
      .T1DONE(b_t1), .T2DONE(b_t2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model per channel (0:A-T1 1:A-T2 2:B-T1 3:B-T2).
   // phase 0 idle, 1 clearing, 2 timing, 3 expired; el = edges since E0.
   int m_len [4] = '{3, 2, 1, 1};
   int m_pre [4] = '{4, 4, 1, 1};
   int m_ph  [4] = '{0, 0, 0, 0};
   int m_el  [4] = '{0, 0, 0, 0};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input logic clr, input logic c1, input logic c2);
      for (int ch = 0; ch < 4; ch++) begin
         logic c;
         c = (ch % 2 == 0) ? c1 : c2;
         if (clr) begin
            m_ph[ch] = 0;
            m_el[ch] = 0;
         end else if (c) begin
            m_ph[ch] = 1;
         end else if (m_ph[ch] == 1) begin
            m_ph[ch] = 2;
            m_el[ch] = 0;
         end else if (m_ph[ch] == 2) begin
            m_el[ch]++;
            if (m_el[ch] == m_len[ch] * m_pre[ch]) m_ph[ch] = 3;
         end
      end
   endtask

   task automatic model_check();
      int act_done [4];
      act_done = '{int'(a_t1), int'(a_t2), int'(b_t1), int'(b_t2)};
      for (int ch = 0; ch < 4; ch++) begin
         chk($sformatf("model_done_ch%0d", ch), act_done[ch], (m_ph[ch] == 3) ? 1 : 0);
      end
`ifdef CARWASH_TIMER_REM_EN
      begin
         int act_rem [4];
         int exp_rem;
         act_rem = '{int'(a_r1), int'(a_r2), int'(b_r1), int'(b_r2)};
         for (int ch = 0; ch < 4; ch++) begin
            if (m_ph[ch] == 1)      exp_rem = m_len[ch];
            else if (m_ph[ch] == 2) exp_rem = m_len[ch] - m_el[ch] / m_pre[ch];
            else                    exp_rem = 0;
            chk($sformatf("model_rem_ch%0d", ch), act_rem[ch], exp_rem);
         end
      end
`endif
   endtask

   task automatic tick(input logic clr, input logic c1, input logic c2);
      CLR   = clr;
      CLRT1 = c1;
      CLRT2 = c2;
      @(posedge clk);
      model_step(clr, c1, c2);
      #1;
      model_check();
   endtask

   typedef struct {
      logic clr;
      logic c1;
      logic c2;
      int   n;
      logic e1;
      logic e2;
   } vec_t;

   vec_t tbl[$];

   initial begin
      CLR = 1'b1; CLRT1 = 1'b0; CLRT2 = 1'b0;

      // Reset and idle hold.
      tbl.push_back('{1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 50, 1'b0, 1'b0});
      // Spray: one-cycle clear, done exactly 12 edges after E0, held, dropped by clear.
      tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0});
      // Restart mid-run after 7 low edges.
      tbl.push_back('{1'b0, 1'b0, 1'b0,  7, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0});
      // Controller sequence: T2 cleared, then T1 cleared while T2 runs.
      tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  7, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1});
      // Reset in the middle of a T2 run; channel stays idle until next clear.
      tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            tick(tbl[i].clr, tbl[i].c1, tbl[i].c2);
            chk($sformatf("tbl%0d_T1DONE", i), int'(a_t1), int'(tbl[i].e1));
            chk($sformatf("tbl%0d_T2DONE", i), int'(a_t2), int'(tbl[i].e2));
         end
      end

      // CLR overrides simultaneous clears; channels remain idle afterwards.
      tick(1'b1, 1'b1, 1'b1);
      chk("clr_override_T1", int'(a_t1), 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("idle_after_clr_B_T1", int'(b_t1), 0);

      // PRESCALE=1, LEN=1: done one edge after E0.
      tick(1'b0, 1'b1, 1'b1);
`ifdef CARWASH_TIMER_REM_EN
      chk("b_rem_load", int'(b_r1), 1);
`endif
      tick(1'b0, 1'b0, 1'b0);
      chk("b_e0_T1DONE", int'(b_t1), 0);
      tick(1'b0, 1'b0, 1'b0);
      chk("b_e1_T1DONE", int'(b_t1), 1);
`ifdef CARWASH_TIMER_REM_EN
      chk("b_rem_done", int'(b_r1), 0);
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 800; k++) begin
         tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/carwash_timer.md
Name: carwash_timer

Overview:
- Timer responder for the car wash controller FSM.
- Accepts the controller's CLRT1 (spray timer clear) and CLRT2 (rinse timer clear) commands, and returns T1DONE and T2DONE.
- Contains two independent down-counters driven by a per-channel prescaler, so wash durations are set in ticks rather than clocks.
- Sits between the controller and the board clock; with the optional feature, it also feeds the PMOD seven-segment display.

Parameters:
- PRESCALE, 100, clk cycles per timer tick (>=1).
- T1_LEN, 5, spray duration in ticks (>=1).
- T2_LEN, 8, rinse duration in ticks (>=1).
- CNT_W, 8, tick counter width; must satisfy T1_LEN, T2_LEN <= 2**CNT_W-1.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- CLR  in  1  synchronous, active-high reset.
- CLRT1  in  1  clear/hold spray timer, active high.
- CLRT2  in  1  clear/hold rinse timer, active high.
- T1DONE  out  1  spray time expired, active high, registered.
- T2DONE  out  1  rinse time expired, active high, registered.
- T1REM  out  CNT_W  remaining spray ticks (only with CARWASH_TIMER_REM_EN).
- T2REM  out  CNT_W  remaining rinse ticks (only with CARWASH_TIMER_REM_EN).

Behaviour:
- Reset values:
  - CLR sampled high forces both channels to IDLE on that edge.
  - Count = 0, prescaler = 0, T1DONE = T2DONE = 0.
  - CLR overrides all other inputs.
- Channels are identical and fully independent; simultaneous CLRT1/CLRT2 activity needs no arbitration.
- Per-channel FSM, states IDLE, LOAD, RUN, DONE:
  - IDLE: DONE=0. CLRTx=1 -> LOAD; otherwise stay. A channel never counts without a prior clear.
  - LOAD: count=LEN, prescaler=0, DONE=0. Stay while CLRTx=1. CLRTx sampled 0 -> RUN.
  - RUN, each edge:
    - CLRTx=1 -> LOAD (restart, count reloaded).
    - Otherwise the prescaler increments. At PRESCALE-1 it wraps to 0 and count decrements.
    - Decrement to 0 -> DONE.
  - DONE: DONE=1, held. CLRTx=1 -> LOAD; otherwise stay.
- Latency:
  - Let edge E0 be the first edge at which CLRTx is sampled 0 while in LOAD.
  - TxDONE is visible high exactly LEN*PRESCALE edges after E0.
  - PRESCALE=1 gives one tick per clock.
- Asserting CLRTx on any edge, including while DONE=1, drops TxDONE on the next edge.
- A clear pulse of one cycle is valid: LOAD for one cycle, then RUN.
- Counter never underflows and never wraps; it is held at 0 in DONE.
- Elaboration error if any parameter is out of range.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: CARWASH_TIMER_REM_EN.
- When defined:
  - T1REM/T2REM ports exist.
  - Each is driven from a register equal to the channel count: LEN in LOAD, the live count in RUN, 0 in IDLE and DONE.
  - Updated on the same edge as the count.
- When undefined: the ports and their logic are absent. T1DONE/T2DONE timing is identical in both builds.

Decomposition:
- Package carwash_pkg holds:
  - Enum timer_state_t {IDLE, LOAD, RUN, DONE} (one-hot encoding, as in the controller).
  - Default constants CW_PRESCALE, CW_T1_LEN, CW_T2_LEN, CW_CNT_W.
- Sub-module wash_timer: one channel, with parameters PRESCALE, LEN, CNT_W and ports clk, CLR, clr_in, done, rem.
  - carwash_timer instantiates it twice (LEN=T1_LEN and LEN=T2_LEN).

Test Plan (PRESCALE=4, T1_LEN=3, T2_LEN=2 unless noted):
- Reset: CLR high 2 cycles with CLRT1=CLRT2=0 -> T1DONE=T2DONE=0, held for 50 cycles with no clear applied.
- Spray timing: CLRT1=1 for 1 cycle then 0 -> T1DONE rises exactly 12 edges after E0, stays high until CLRT1 is reasserted, and falls on the next edge.
- Restart mid-run: CLRT1 low for 7 edges, then high 1 cycle, then low -> no T1DONE at edge 12 of the first run; rises 12 edges after the new E0.
- Independent channels with full controller sequence (CLRT1 low / CLRT2 high, then CLRT1 high / CLRT2 low):
  - T1DONE at 12 edges.
  - T2DONE at 8 edges after its E0.
  - Neither channel perturbs the other.
- Reset mid-run: CLR asserted at edge 5 of a T2 run -> T2DONE=0, and the channel stays IDLE until the next CLRT2.
- PRESCALE=1, T1_LEN=1 with REM_EN: T1DONE high 1 edge after E0; T1REM reads 1 in LOAD and 0 in DONE.
